preempt_ctrl: RTL

Quantum-based preemption controller for the multiprogrammed processor. Consumes the register bank's exported state: current PC (bank reg 11), current program id (reg 24) and quantum (reg 29). It counts retired user instructions and, on quantum expiry, produces the bank's `save` strobe (PC into reg 10), then a PC redirect to the OS handler. It sits between the register bank and the PC-select/stall logic of the datapath.

---
 rtl/preempt_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/preempt_ctrl.sv
// Quantum-based preemption controller.
// Counts user instructions retired in the current time slice. When the quantum
// expires it strobes the register bank's save, redirects the PC to the OS
// handler, and then waits until the OS is running before arming again.
module preempt_ctrl #(
  parameter int          OS_LIMIT     = 3000,
  parameter logic [31:0] HANDLER_ADDR = 32'd0,
  parameter int          CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      pc_atual,
  input  logic [31:0]      prog_atual,
  input  logic [31:0]      quantum,
  input  logic             instr_valid,
  output logic             save,
  output logic             desvio,
  output logic [31:0]      desvio_addr,
  output logic             stall,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      last_prog,
  output logic [15:0]      n_preempt
);

  typedef enum logic [2:0] {IDLE, RUN, SAVE, JUMP, WAIT_OS} state_t;

  // The compare width is wide enough for both count+1 and the 32-bit quantum.
  localparam int          CW    = (CNT_W >= 32) ? CNT_W + 1 : 33;
  localparam logic [31:0] LIMIT = 32'(OS_LIMIT);

  state_t           state;
  logic             user;
  logic             expire;
  logic [CNT_W-1:0] cnt_sat;

  // pc == OS_LIMIT is still user code.
  assign user    = pc_atual >= LIMIT;
  // Use >= so a quantum lowered below the current count expires on the next retire.
  assign expire  = (CW'(count) + CW'(1)) >= CW'(quantum);
  // The counter holds at all-ones and never wraps.
  assign cnt_sat = (count == '1) ? count : count + 1'b1;

  assign desvio_addr = HANDLER_ADDR;

  // FSM with registered strobes. SAVE and JUMP ignore their inputs, so a
  // preemption that has started always completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      save      <= 1'b0;
      desvio    <= 1'b0;
      stall     <= 1'b0;
      count     <= '0;
      last_prog <= '0;
      n_preempt <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (enable && quantum != 32'd0 && user) state <= RUN;
        end
        RUN: begin
          // Exit conditions take priority over expiry.
          if (!user || !enable || quantum == 32'd0) begin
            state <= IDLE;
            count <= '0;
          end else if (instr_valid) begin
            count <= cnt_sat;
            if (expire) begin
              state <= SAVE;
              save  <= 1'b1;
              stall <= 1'b1;
            end
          end
        end
        SAVE: begin
          save      <= 1'b0;
          desvio    <= 1'b1;
          last_prog <= prog_atual;
          n_preempt <= n_preempt + 16'd1;
          state     <= JUMP;
        end
        JUMP: begin
          desvio <= 1'b0;
          stall  <= 1'b0;
          state  <= WAIT_OS;
        end
        WAIT_OS: begin
          // count stays frozen until the OS handler is actually running.
          if (!user) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          save   <= 1'b0;
          desvio <= 1'b0;
          stall  <= 1'b0;
          count  <= '0;
        end
      endcase
    end
  end

endmodule
